mempool_tile_resp_queue: RTL and testbench
==========================================

# mempool_tile_resp_queue

Multi-lane response queue that sits directly upstream of the tile response arbiter: one small FIFO per bank-response lane, decoupling bank read latency from arbiter back-pressure. Each lane presents its oldest entry to the arbiter with a valid/ready handshake. Each lane also reports occupancy and a saturating head-of-line stall counter with a starvation flag, which downstream priority logic uses.

## Interface
- NumLanes, 16: number of independent response lanes (one per bank port); ≥1.
- Depth, 4: entries per lane FIFO; power of two, ≥2.
- StallCntWidth, 4: width of the per-lane head-of-line stall counter.
- StarveThresh, 8: stall count at or above which the lane's starvation flag asserts; must be < 2^StallCntWidth.
- payload_t, logic: response payload type, stored and forwarded unmodified.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  NumLanes×payload_t  push payload per lane.
- valid_i  in  NumLanes  push request per lane.
- ready_o  out  NumLanes  lane can accept a push (not full).
- data_o  out  NumLanes×payload_t  head entry per lane (toward arbiter).
- valid_o  out  NumLanes  lane non-empty.
- ready_i  in  NumLanes  arbiter accepts head entry.
- occupancy_o  out  NumLanes×$clog2(Depth+1)  entries held per lane.
- stall_cnt_o  out  NumLanes×StallCntWidth  cycles current head has waited unaccepted.
- starve_o  out  NumLanes  stall_cnt_o ≥ StarveThresh.

## Operation
- Lanes are fully independent; every rule below applies per lane.
- Storage: Depth-entry circular buffer, write pointer and read pointer of $clog2(Depth) bits wrapping modulo Depth, plus an occupancy counter 0..Depth.
- Push when valid_i & ready_o: write data_i at wptr, wptr+1 mod Depth.
- Pop when valid_o & ready_i: rptr+1 mod Depth.
- Occupancy next = occ + push − pop; simultaneous push and pop leaves occupancy unchanged.
- ready_o = (occ != Depth); depends only on registered state, with no combinational path from ready_i. When full, a push is refused even if a pop happens in the same cycle.
- valid_o = (occ != 0); data_o = buffer[rptr]. data_o is don't-care when valid_o is low.
- No fall-through: an entry pushed into an empty lane is not visible on the same cycle.
- Stall counter:
  - Cleared when the lane is empty, or on any cycle with a pop.
  - Otherwise, when valid_o & ~ready_i, increments by 1, saturating at 2^StallCntWidth−1 (never wraps).
  - It therefore measures waiting of the current head only.
- starve_o is decoded combinationally from the registered stall counter.
- Payload content is never inspected or altered; ordering within a lane is strict FIFO.

## Timing
- Reset (rst_i high at a clock edge):
  - Pointers, occupancy and stall counters clear.
  - Next cycle: ready_o all 1, valid_o all 0, occupancy_o 0, stall_cnt_o 0, starve_o 0.
  - Stored data is not cleared.
- Reset asserted mid-operation discards all queued entries. Pushes or pops presented in the reset cycle have no effect.
- Push-to-visible latency is 1 cycle: a push at cycle t makes valid_o high and data_o valid at t+1.
- Pop at cycle t makes the next entry visible at t+1. A lane with occ=1 that both pops and pushes at t shows the new entry at t+1.
- A lane reaching occ=Depth at cycle t drives ready_o low from t+1. The first pop at t+k raises ready_o at t+k+1.
- Stall counter: head valid from cycle t with ready_i low shows stall_cnt_o = n at cycle t+n. starve_o rises at t+StarveThresh.
- Throughput: one push and one pop per lane per cycle, sustained while 0<occ<Depth.

## Test plan
- Reset then single lane 0: push A at t0, hold ready_i=1 → valid_o[0]=1, data_o[0]=A at t0+1; pop at t0+1; valid_o[0]=0 at t0+2; other lanes stay idle.
- Fill (Depth=4): push A,B,C,D back-to-back on lane 3 with ready_i=0 → occupancy_o[3]=4 and ready_o[3]=0 after the 4th push. A 5th push E is refused. A pop then raises ready_o[3] one cycle later. Drain order is A,B,C,D; E is never emitted.
- Wrap-around: 10 interleaved push/pop pairs on one lane with occ held at 1–3 → output sequence equals input sequence across pointer wraps.
- Simultaneous push+pop at occ=2 → occupancy stays 2, FIFO order preserved. At occ=4, push plus pop → push refused, occupancy goes to 3.
- Stall (StallCntWidth=4, StarveThresh=8): head held with ready_i=0 for 20 cycles → stall_cnt_o counts 1..15 and saturates at 15. starve_o rises exactly 8 cycles after valid. A pop clears the counter to 0 next cycle, even though the lane is still non-empty.
- Reset mid-operation with lanes at occ 3 and stall 5 → one cycle later all valid_o=0, ready_o=1, counters 0. A subsequent push restarts cleanly.

Source files
------------

// File: rtl/mempool_tile_resp_queue.sv
// Per-lane response FIFOs in front of the tile response arbiter, with occupancy,
// head-of-line stall counting and a starvation flag for downstream priority logic.
module mempool_tile_resp_queue #(
  parameter int unsigned NumLanes      = 16,
  parameter int unsigned Depth         = 4,
  parameter int unsigned StallCntWidth = 4,
  parameter int unsigned StarveThresh  = 8,
  parameter type         payload_t     = logic
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  payload_t [NumLanes-1:0]                     data_i,
  input  logic [NumLanes-1:0]                         valid_i,
  output logic [NumLanes-1:0]                         ready_o,
  output payload_t [NumLanes-1:0]                     data_o,
  output logic [NumLanes-1:0]                         valid_o,
  input  logic [NumLanes-1:0]                         ready_i,
  output logic [NumLanes-1:0][$clog2(Depth+1)-1:0]    occupancy_o,
  output logic [NumLanes-1:0][StallCntWidth-1:0]      stall_cnt_o,
  output logic [NumLanes-1:0]                         starve_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccWidth = $clog2(Depth + 1);
  localparam logic [OccWidth-1:0]      OccFull   = OccWidth'(Depth);
  localparam logic [StallCntWidth-1:0] StarveThr = StallCntWidth'(StarveThresh);

  // Handshake: a transfer happens on a side exactly when valid and ready are both
  // high at a rising edge; ready_o and valid_o depend only on registered state.

  payload_t                                mem [NumLanes][Depth];
  logic [NumLanes-1:0][PtrWidth-1:0]       wptr_q;
  logic [NumLanes-1:0][PtrWidth-1:0]       rptr_q;
  logic [NumLanes-1:0][OccWidth-1:0]       occ_q;
  logic [NumLanes-1:0][StallCntWidth-1:0]  stall_q;
  logic [NumLanes-1:0]                     push;
  logic [NumLanes-1:0]                     pop;

  always_comb begin
    ready_o  = '0;
    valid_o  = '0;
    data_o   = '0;
    starve_o = '0;
    push     = '0;
    pop      = '0;
    for (int l = 0; l < NumLanes; l++) begin
      // A full lane refuses pushes even when it pops in the same cycle.
      ready_o[l]  = (occ_q[l] != OccFull);
      valid_o[l]  = (occ_q[l] != '0);
      data_o[l]   = mem[l][rptr_q[l]];
      starve_o[l] = (stall_q[l] >= StarveThr);
      push[l]     = valid_i[l] & ready_o[l];
      pop[l]      = valid_o[l] & ready_i[l];
    end
  end

  assign occupancy_o = occ_q;
  assign stall_cnt_o = stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      for (int l = 0; l < NumLanes; l++) begin
        if (push[l]) wptr_q[l] <= wptr_q[l] + 1'b1;
        if (pop[l])  rptr_q[l] <= rptr_q[l] + 1'b1;
        if (push[l] && !pop[l]) begin
          occ_q[l] <= occ_q[l] + 1'b1;
        end else if (!push[l] && pop[l]) begin
          occ_q[l] <= occ_q[l] - 1'b1;
        end
        // Counts only the current head: an empty lane or a pop restarts it.
        if (!valid_o[l] || pop[l]) begin
          stall_q[l] <= '0;
        end else if (stall_q[l] != '1) begin
          stall_q[l] <= stall_q[l] + 1'b1;
        end
      end
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NumLanes; l++) begin
      if (push[l] && !rst_i) mem[l][wptr_q[l]] <= data_i[l];
    end
  end

endmodule

// File: tb/tb_mempool_tile_resp_queue.sv
// Directed bench for mempool_tile_resp_queue: a vector table for single-lane
// sequences plus hand-written wrap, stall and mid-operation reset sequences.
module tb_mempool_tile_resp_queue;

  localparam int NL = 16;
  localparam int D  = 4;
  localparam int SW = 4;
  localparam int ST = 8;
  localparam int OW = $clog2(D + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NL-1:0][7:0]       data_i;
  logic [NL-1:0]            valid_i;
  logic [NL-1:0]            ready_o;
  logic [NL-1:0][7:0]       data_o;
  logic [NL-1:0]            valid_o;
  logic [NL-1:0]            ready_i;
  logic [NL-1:0][OW-1:0]    occupancy_o;
  logic [NL-1:0][SW-1:0]    stall_cnt_o;
  logic [NL-1:0]            starve_o;

  mempool_tile_resp_queue #(
    .NumLanes(NL), .Depth(D), .StallCntWidth(SW), .StarveThresh(ST),
    .payload_t(logic [7:0])
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o), .starve_o(starve_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         lane;
    bit         push;
    logic [7:0] pdata;
    bit         rdy;
    bit         ev;
    logic [7:0] ed;
    bit         er;
    int         eocc;
    int         estall;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input bit push, input logic [7:0] d, input bit rdy);
    valid_i = '0;
    ready_i = '0;
    data_i  = '0;
    valid_i[lane] = push;
    ready_i[lane] = rdy;
    data_i[lane]  = d;
  endtask

  // Expected outputs are those seen in the cycle before the listed inputs are applied.
  task automatic add(input int lane, input bit push, input logic [7:0] pd, input bit rdy,
                     input bit ev, input logic [7:0] ed, input bit er,
                     input int eocc, input int estall);
    vec_t v;
    v.lane = lane; v.push = push; v.pdata = pd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.er = er; v.eocc = eocc; v.estall = estall;
    vecs.push_back(v);
  endtask

  task automatic chk_lane(input string tag, input int lane, input bit ev, input logic [7:0] ed,
                          input bit er, input int eocc, input int estall);
    chk({tag, " valid"}, 64'(valid_o[lane]), 64'(ev));
    chk({tag, " ready"}, 64'(ready_o[lane]), 64'(er));
    chk({tag, " occ"}, 64'(occupancy_o[lane]), 64'(eocc));
    chk({tag, " stall"}, 64'(stall_cnt_o[lane]), 64'(estall));
    chk({tag, " starve"}, 64'(starve_o[lane]), 64'(estall >= ST));
    if (ev) chk({tag, " data"}, 64'(data_o[lane]), 64'(ed));
  endtask

  initial begin
    // Lane 0: single push then pop.
    add(0, 1, 8'hA1, 1, 0, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'hA1, 1, 1, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    // Lane 3: fill to Depth, refused fifth push, drain in order.
    add(3, 1, 8'h31, 0, 0, 8'h00, 1, 0, 0);
    add(3, 1, 8'h32, 0, 1, 8'h31, 1, 1, 0);
    add(3, 1, 8'h33, 0, 1, 8'h31, 1, 2, 1);
    add(3, 1, 8'h34, 0, 1, 8'h31, 1, 3, 2);
    add(3, 1, 8'h35, 0, 1, 8'h31, 0, 4, 3);
    add(3, 0, 8'h00, 1, 1, 8'h31, 0, 4, 4);
    add(3, 0, 8'h00, 1, 1, 8'h32, 1, 3, 0);
    add(3, 0, 8'h00, 1, 1, 8'h33, 1, 2, 0);
    add(3, 0, 8'h00, 1, 1, 8'h34, 1, 1, 0);
    add(3, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    // Lane 5: push+pop at occ 2 holds occupancy; at occ 4 the push is refused.
    add(5, 1, 8'h51, 0, 0, 8'h00, 1, 0, 0);
    add(5, 1, 8'h52, 0, 1, 8'h51, 1, 1, 0);
    add(5, 1, 8'h53, 1, 1, 8'h51, 1, 2, 1);
    add(5, 1, 8'h54, 0, 1, 8'h52, 1, 2, 0);
    add(5, 1, 8'h55, 0, 1, 8'h52, 1, 3, 1);
    add(5, 1, 8'h56, 1, 1, 8'h52, 0, 4, 2);
    add(5, 0, 8'h00, 1, 1, 8'h53, 1, 3, 0);
    add(5, 0, 8'h00, 1, 1, 8'h54, 1, 2, 0);
    add(5, 0, 8'h00, 1, 1, 8'h55, 1, 1, 0);
    add(5, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);

    // Reset
    rst = 1'b1; valid_i = '0; ready_i = '0; data_i = '0;
    step(); step();
    rst = 1'b0;
    chk("reset ready_o", 64'(ready_o), 64'(16'hFFFF));
    chk("reset valid_o", 64'(valid_o), 64'h0);
    chk("reset occupancy_o", 64'(occupancy_o), 64'h0);
    chk("reset stall_cnt_o", 64'(stall_cnt_o), 64'h0);
    chk("reset starve_o", 64'(starve_o), 64'h0);

    // Table-driven single-lane sequences
    for (int i = 0; i < vecs.size(); i++) begin
      logic [NL-1:0] others;
      chk_lane($sformatf("vec%0d lane%0d", i, vecs[i].lane), vecs[i].lane, vecs[i].ev,
               vecs[i].ed, vecs[i].er, vecs[i].eocc, vecs[i].estall);
      others = valid_o;
      others[vecs[i].lane] = 1'b0;
      chk($sformatf("vec%0d idle lanes", i), 64'(others), 64'h0);
      drive(vecs[i].lane, vecs[i].push, vecs[i].pdata, vecs[i].rdy);
      step();
    end
    drive(0, 0, 8'h00, 0);

    // Wrap-around on lane 7: 10 push/pop pairs at occ 2
    drive(7, 1, 8'h70, 0); exp_q.push_back(8'h70); step();
    drive(7, 1, 8'h71, 0); exp_q.push_back(8'h71); step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap%0d occ", i), 64'(occupancy_o[7]), 64'd2);
      chk($sformatf("wrap%0d valid", i), 64'(valid_o[7]), 64'd1);
      chk($sformatf("wrap%0d data", i), 64'(data_o[7]), 64'(exp_q[0]));
      drive(7, 1, 8'(8'h72 + i), 1);
      exp_q.push_back(8'(8'h72 + i));
      void'(exp_q.pop_front());
      step();
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      chk($sformatf("wrap drain%0d data", i), 64'(data_o[7]), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      drive(7, 0, 8'h00, 1);
      step();
    end
    chk("wrap drained valid", 64'(valid_o[7]), 64'd0);
    drive(0, 0, 8'h00, 0);

    // Stall counting and saturation on lane 9
    drive(9, 1, 8'h99, 0); step();
    chk_lane("stall n0", 9, 1, 8'h99, 1, 1, 0);
    drive(9, 1, 8'h9A, 0); step();
    for (int n = 1; n <= 20; n++) begin
      chk($sformatf("stall n%0d cnt", n), 64'(stall_cnt_o[9]), 64'((n > 15) ? 15 : n));
      chk($sformatf("stall n%0d starve", n), 64'(starve_o[9]), 64'(n >= ST));
      drive(9, 0, 8'h00, n == 20);
      step();
    end
    chk_lane("stall after pop", 9, 1, 8'h9A, 1, 1, 0);
    drive(9, 0, 8'h00, 1); step();
    chk("stall lane empty", 64'(valid_o[9]), 64'd0);
    drive(0, 0, 8'h00, 0);

    // Reset mid-operation with lanes 0..2 at occ 3, stall 5
    ready_i = '0;
    for (int c = 0; c < 3; c++) begin
      valid_i = 16'h0007;
      for (int l = 0; l < NL; l++) data_i[l] = 8'(8'hC0 + 16 * c + l);
      step();
    end
    valid_i = '0;
    step(); step(); step();
    chk_lane("pre-reset lane0", 0, 1, 8'hC0, 1, 3, 5);
    chk_lane("pre-reset lane2", 2, 1, 8'hC2, 1, 3, 5);
    rst = 1'b1; valid_i = '1; ready_i = '1;
    step();
    rst = 1'b0; valid_i = '0; ready_i = '0;
    chk("midrst valid_o", 64'(valid_o), 64'h0);
    chk("midrst ready_o", 64'(ready_o), 64'(16'hFFFF));
    chk("midrst occupancy_o", 64'(occupancy_o), 64'h0);
    chk("midrst stall_cnt_o", 64'(stall_cnt_o), 64'h0);
    chk("midrst starve_o", 64'(starve_o), 64'h0);
    drive(0, 1, 8'hC7, 0); step();
    drive(0, 0, 8'h00, 0);
    chk("restart valid_o", 64'(valid_o), 64'h1);
    chk_lane("restart lane0", 0, 1, 8'hC7, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
